// File: rtl/shift_reg_univ_if.sv
// -----------------------------------------------------------------------------
// shift_reg_univ_if
//   Groups the operation/control inputs and register/status outputs of
//   shift_reg_univ into one bundle. Clock and reset stay plain module ports.
//
//   master : driver side (issues en/mode/d/sin/start/cnt, observes outputs)
//   slave  : register side (shift_reg_univ)
//
//   Signals
//     en      operation enable (low = hold, pauses a burst)
//     mode    3-bit operation select
//     d       parallel load data
//     sin     serial input
//     start   burst request
//     cnt     burst shift count
//     q       register contents
//     sout_l  q[WIDTH-1]
//     sout_r  q[0]
//     busy    burst in progress
//     done    one-cycle burst completion pulse
//
//   Optional (SHIFT_REG_PARITY_EN defined):
//     p_in    expected even parity of d on a load
//     parity  ^q
//     par_err registered parity mismatch flag
// -----------------------------------------------------------------------------
interface shift_reg_univ_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = $clog2(WIDTH + 1)
);
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin;
    logic             start;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] q;
    logic             sout_l;
    logic             sout_r;
    logic             busy;
    logic             done;
`ifdef SHIFT_REG_PARITY_EN
    logic             p_in;
    logic             parity;
    logic             par_err;

    modport master (
        output en, mode, d, sin, start, cnt, p_in,
        input  q, sout_l, sout_r, busy, done, parity, par_err
    );

    modport slave (
        input  en, mode, d, sin, start, cnt, p_in,
        output q, sout_l, sout_r, busy, done, parity, par_err
    );
`else
    modport master (
        output en, mode, d, sin, start, cnt,
        input  q, sout_l, sout_r, busy, done
    );

    modport slave (
        input  en, mode, d, sin, start, cnt,
        output q, sout_l, sout_r, busy, done
    );
`endif
endinterface

// File: rtl/shift_reg_univ.sv
// -----------------------------------------------------------------------------
// shift_reg_univ
//   Parametrised universal shift register. Every enabled clock performs one of
//   hold / shl / shr / rotl / rotr / load / clear. A burst engine repeats a
//   shift or rotate for a programmed number of enabled edges, flagging busy
//   while running and pulsing done for one cycle on completion.
//
//   Parameters
//     WIDTH  register width (>= 2)
//     CW     width of the burst count
//
//   Ports
//     clk    rising-edge clock
//     reset  asynchronous active-low reset (clears q, busy, done, burst state)
//     bus    shift_reg_univ_if.slave, operation inputs and status outputs
//
//   Optional feature macro: SHIFT_REG_PARITY_EN
//     Adds bus.parity (^q), bus.par_err (latched (^d)^p_in on load, cleared
//     on clear mode or reset) and the bus.p_in input.
// -----------------------------------------------------------------------------
module shift_reg_univ #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic           clk,
    input  logic           reset,
    shift_reg_univ_if.slave bus
);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHL   = 3'b001,
        MODE_SHR   = 3'b010,
        MODE_ROTL  = 3'b011,
        MODE_ROTR  = 3'b100,
        MODE_LOAD  = 3'b101,
        MODE_CLEAR = 3'b110,
        MODE_RSVD  = 3'b111
    } mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e           state_q, state_d;
    mode_e            bmode_q, bmode_d;
    logic [CW-1:0]    rem_q,   rem_d;
    logic [WIDTH-1:0] q_q,     q_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
`ifdef SHIFT_REG_PARITY_EN
    logic             par_err_q, par_err_d;
`endif

    mode_e            mode_in;
    logic             is_shift;

    // Single-step next value of the register for a given operation.
    function automatic logic [WIDTH-1:0] apply_op(
        input mode_e            op,
        input logic [WIDTH-1:0] cur,
        input logic             s
    );
        logic [WIDTH-1:0] nxt;
        nxt = cur;
        case (op)
            MODE_SHL:   nxt = {cur[WIDTH-2:0], s};
            MODE_SHR:   nxt = {s, cur[WIDTH-1:1]};
            MODE_ROTL:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
            MODE_ROTR:  nxt = {cur[0], cur[WIDTH-1:1]};
            MODE_LOAD:  nxt = bus.d;
            MODE_CLEAR: nxt = '0;
            default:    nxt = cur;
        endcase
        return nxt;
    endfunction

    assign mode_in  = mode_e'(bus.mode);
    assign is_shift = (mode_in == MODE_SHL)  || (mode_in == MODE_SHR) ||
                      (mode_in == MODE_ROTL) || (mode_in == MODE_ROTR);

    always_comb begin
        state_d = state_q;
        bmode_d = bmode_q;
        rem_d   = rem_q;
        q_d     = q_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SHIFT_REG_PARITY_EN
        par_err_d = par_err_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    if (bus.start && is_shift) begin
                        // A burst request with a shift/rotate mode never
                        // moves q on the request edge; a zero count completes
                        // immediately with just the done pulse.
                        if (bus.cnt != '0) begin
                            bmode_d = mode_in;
                            rem_d   = bus.cnt;
                            state_d = BURST;
                            busy_d  = 1'b1;
                        end else begin
                            done_d  = 1'b1;
                        end
                    end else begin
                        q_d = apply_op(mode_in, q_q, bus.sin);
`ifdef SHIFT_REG_PARITY_EN
                        if (mode_in == MODE_LOAD) begin
                            par_err_d = (^bus.d) ^ bus.p_in;
                        end else if (mode_in == MODE_CLEAR) begin
                            par_err_d = 1'b0;
                        end
`endif
                    end
                end
            end

            BURST: begin
                if (bus.en) begin
                    q_d   = apply_op(bmode_q, q_q, bus.sin);
                    rem_d = rem_q - CW'(1);
                    if (rem_q == CW'(1)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            bmode_q <= MODE_HOLD;
            rem_q   <= '0;
            q_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SHIFT_REG_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bmode_q <= bmode_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SHIFT_REG_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    assign bus.q      = q_q;
    assign bus.sout_l = q_q[WIDTH-1];
    assign bus.sout_r = q_q[0];
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
`ifdef SHIFT_REG_PARITY_EN
    assign bus.parity  = ^q_q;
    assign bus.par_err = par_err_q;
`endif

endmodule

// File: tb/tb_shift_reg_univ.sv
// -----------------------------------------------------------------------------
// tb_shift_reg_univ
//   Directed bench for shift_reg_univ (WIDTH=8). Each task drives one scenario
//   and compares outputs against hand-computed values, sampling 1 ns after the
//   rising edge.
// -----------------------------------------------------------------------------
module tb_shift_reg_univ;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    shift_reg_univ_if #(.WIDTH(8), .CW(4)) bus ();

    shift_reg_univ #(.WIDTH(8), .CW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [2:0] m, input logic [7:0] dv,
                         input logic s, input logic st, input logic [3:0] c);
        bus.en    = e;
        bus.mode  = m;
        bus.d     = dv;
        bus.sin   = s;
        bus.start = st;
        bus.cnt   = c;
    endtask

    task automatic test_reset();
        drive(1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 4'd0);
`ifdef SHIFT_REG_PARITY_EN
        bus.p_in = 1'b0;
`endif
        reset = 1'b0;
        #2;
        tests++;
        if (bus.q !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: q=%h busy=%b done=%b, expected q=00 busy=0 done=0",
                     bus.q, bus.busy, bus.done);
        end
`ifdef SHIFT_REG_PARITY_EN
        tests++;
        if (bus.parity !== 1'b0 || bus.par_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_parity: parity=%b par_err=%b, expected 0 0",
                     bus.parity, bus.par_err);
        end
`endif
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 3'b101, 8'hA5, 1'b0, 1'b0, 4'd0);
        tick();
        tests++;
        if (bus.q !== 8'hA5) begin
            fails++;
            $display("FAIL mid_reset_load: q=%h expected a5", bus.q);
        end
        #3;
        reset = 1'b0;
        #1;
        tests++;
        if (bus.q !== 8'h00 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_async: q=%h busy=%b expected q=00 busy=0", bus.q, bus.busy);
        end
        tick();
        tests++;
        if (bus.q !== 8'h00) begin
            fails++;
            $display("FAIL mid_reset_held: q=%h expected 00", bus.q);
        end
        reset = 1'b1;
        drive(1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 4'd0);
        tick();
    endtask

    task automatic test_single_ops();
        logic [2:0] m_v   [8] = '{3'b101, 3'b001, 3'b010, 3'b100, 3'b011, 3'b110, 3'b101, 3'b111};
        logic [7:0] d_v   [8] = '{8'h81,  8'hFF,  8'hFF,  8'h00,  8'h00,  8'hFF,  8'h5A,  8'h00};
        logic       s_v   [8] = '{1'b0,   1'b1,   1'b0,   1'b1,   1'b1,   1'b1,   1'b0,   1'b1};
        logic [7:0] exp_v [8] = '{8'h81,  8'h03,  8'h01,  8'h80,  8'h01,  8'h00,  8'h5A,  8'h5A};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, m_v[i], d_v[i], s_v[i], 1'b0, 4'd0);
            tick();
            tests++;
            if (bus.q !== exp_v[i] || bus.sout_l !== exp_v[i][7] || bus.sout_r !== exp_v[i][0]) begin
                fails++;
                $display("FAIL single_op[%0d]: q=%h sl=%b sr=%b expected q=%h", i,
                         bus.q, bus.sout_l, bus.sout_r, exp_v[i]);
            end
        end
        drive(1'b0, 3'b001, 8'h00, 1'b1, 1'b1, 4'd3);
        tick();
        tests++;
        if (bus.q !== 8'h5A || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL en_low_hold: q=%h busy=%b expected q=5a busy=0", bus.q, bus.busy);
        end
    endtask

    task automatic test_burst();
        logic [7:0] exp_v [3] = '{8'h02, 8'h04, 8'h08};
        int done_cnt;
        done_cnt = 0;
        drive(1'b1, 3'b101, 8'h01, 1'b0, 1'b0, 4'd0);
        tick();
        drive(1'b1, 3'b011, 8'h00, 1'b0, 1'b1, 4'd3);
        tick();
        tests++;
        if (bus.q !== 8'h01 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL burst_start: q=%h busy=%b done=%b expected q=01 busy=1 done=0",
                     bus.q, bus.busy, bus.done);
        end
        drive(1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 4'd0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (bus.done === 1'b1) done_cnt++;
            tests++;
            if (bus.q !== exp_v[k-1] || bus.busy !== (k < 3) || bus.done !== (k == 3)) begin
                fails++;
                $display("FAIL burst_edge[%0d]: q=%h busy=%b done=%b expected q=%h busy=%b done=%b",
                         k, bus.q, bus.busy, bus.done, exp_v[k-1], (k < 3), (k == 3));
            end
        end
        tick();
        if (bus.done === 1'b1) done_cnt++;
        tests++;
        if (done_cnt != 1 || bus.q !== 8'h08) begin
            fails++;
            $display("FAIL burst_done_once: pulses=%0d q=%h expected pulses=1 q=08", done_cnt, bus.q);
        end
    endtask

    task automatic test_burst_pause();
        logic [7:0] exp_v [12] = '{8'hFE, 8'hFC, 8'hF8, 8'hF8, 8'hF8, 8'hF0,
                                   8'hE0, 8'hC0, 8'h80, 8'h00, 8'h00, 8'h00};
        drive(1'b1, 3'b101, 8'hFF, 1'b0, 1'b0, 4'd0);
        tick();
        drive(1'b1, 3'b001, 8'h00, 1'b0, 1'b1, 4'd10);
        tick();
        tests++;
        if (bus.q !== 8'hFF || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL pause_start: q=%h busy=%b expected q=ff busy=1", bus.q, bus.busy);
        end
        for (int k = 1; k <= 12; k++) begin
            drive(!(k == 4 || k == 5), (k % 2 == 1) ? 3'b101 : 3'b110, 8'hA5, 1'b0,
                  (k % 2 == 0), 4'd2);
            tick();
            tests++;
            if (bus.q !== exp_v[k-1] || bus.busy !== (k < 12) || bus.done !== (k == 12)) begin
                fails++;
                $display("FAIL pause_edge[%0d]: q=%h busy=%b done=%b expected q=%h busy=%b done=%b",
                         k, bus.q, bus.busy, bus.done, exp_v[k-1], (k < 12), (k == 12));
            end
        end
        drive(1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 4'd0);
        tick();
        tests++;
        if (bus.done !== 1'b0 || bus.q !== 8'h00) begin
            fails++;
            $display("FAIL pause_after: done=%b q=%h expected done=0 q=00", bus.done, bus.q);
        end
    endtask

    task automatic test_edge_cases();
        drive(1'b1, 3'b101, 8'h3C, 1'b0, 1'b0, 4'd0);
        tick();
        drive(1'b1, 3'b001, 8'h00, 1'b1, 1'b1, 4'd0);
        tick();
        tests++;
        if (bus.q !== 8'h3C || bus.busy !== 1'b0 || bus.done !== 1'b1) begin
            fails++;
            $display("FAIL cnt_zero: q=%h busy=%b done=%b expected q=3c busy=0 done=1",
                     bus.q, bus.busy, bus.done);
        end
        drive(1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 4'd0);
        tick();
        tests++;
        if (bus.done !== 1'b0 || bus.q !== 8'h3C) begin
            fails++;
            $display("FAIL cnt_zero_pulse: done=%b q=%h expected done=0 q=3c", bus.done, bus.q);
        end
        drive(1'b1, 3'b101, 8'h5A, 1'b0, 1'b1, 4'd3);
        tick();
        tests++;
        if (bus.q !== 8'h5A || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL start_load: q=%h busy=%b done=%b expected q=5a busy=0 done=0",
                     bus.q, bus.busy, bus.done);
        end
        drive(1'b1, 3'b100, 8'h00, 1'b0, 1'b1, 4'd5);
        tick();
        drive(1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 4'd0);
        tick();
        tests++;
        if (bus.q !== 8'h2D || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL abort_pre: q=%h busy=%b expected q=2d busy=1", bus.q, bus.busy);
        end
        #2;
        reset = 1'b0;
        #1;
        tests++;
        if (bus.q !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL abort_async: q=%h busy=%b done=%b expected 00 0 0",
                     bus.q, bus.busy, bus.done);
        end
        tick();
        reset = 1'b1;
        drive(1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 4'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            tests++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.q !== 8'h00) begin
                fails++;
                $display("FAIL abort_no_done[%0d]: done=%b busy=%b q=%h expected 0 0 00",
                         k, bus.done, bus.busy, bus.q);
            end
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 3'b101, 8'h01, 1'b0, 1'b0, 4'd0);
        tick();
        drive(1'b1, 3'b011, 8'h00, 1'b0, 1'b1, 4'd1);
        tick();
        drive(1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 4'd0);
        tick();
        tests++;
        if (bus.q !== 8'h02 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_first: q=%h done=%b busy=%b expected q=02 done=1 busy=0",
                     bus.q, bus.done, bus.busy);
        end
        drive(1'b1, 3'b100, 8'h00, 1'b0, 1'b1, 4'd2);
        tick();
        tests++;
        if (bus.q !== 8'h02 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL b2b_restart: q=%h busy=%b done=%b expected q=02 busy=1 done=0",
                     bus.q, bus.busy, bus.done);
        end
        drive(1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 4'd0);
        tick();
        tick();
        tests++;
        if (bus.q !== 8'h80 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_second: q=%h done=%b busy=%b expected q=80 done=1 busy=0",
                     bus.q, bus.done, bus.busy);
        end
    endtask

`ifdef SHIFT_REG_PARITY_EN
    task automatic test_parity();
        drive(1'b1, 3'b101, 8'h07, 1'b0, 1'b0, 4'd0);
        bus.p_in = 1'b0;
        tick();
        tests++;
        if (bus.parity !== 1'b1 || bus.par_err !== 1'b1) begin
            fails++;
            $display("FAIL parity_load: parity=%b par_err=%b expected 1 1", bus.parity, bus.par_err);
        end
        drive(1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 4'd0);
        tick();
        tests++;
        if (bus.parity !== 1'b0 || bus.par_err !== 1'b0) begin
            fails++;
            $display("FAIL parity_clear: parity=%b par_err=%b expected 0 0", bus.parity, bus.par_err);
        end
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_reset_mid();
        test_single_ops();
        test_burst();
        test_burst_pause();
        test_edge_cases();
        test_back_to_back();
`ifdef SHIFT_REG_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
